// File: rtl/snake_pkg.sv
// Shared types and playfield constants for the snake body store.
// Tile coordinates stay inside x 1..20, y 0..14; x 0 and 21 are border columns.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    dir_t       dir;
  } seg_t;

  localparam logic [4:0] GRID_X_MIN = 5'd1;
  localparam logic [4:0] GRID_X_MAX = 5'd20;
  localparam logic [3:0] GRID_Y_MAX = 4'd14;

  localparam logic [4:0] RESET_HEAD_X = 5'd5;
  localparam logic [3:0] RESET_HEAD_Y = 4'd7;
  localparam logic [6:0] RESET_LEN    = 7'd3;

  // One tile step with torus wrap; the result carries the move direction.
  function automatic seg_t step_seg(input logic [4:0] x, input logic [3:0] y,
                                    input dir_t d);
    seg_t s;
    s.x   = x;
    s.y   = y;
    s.dir = d;
    case (d)
      DIR_RIGHT: s.x = (x >= GRID_X_MAX) ? GRID_X_MIN : x + 5'd1;
      DIR_LEFT:  s.x = (x <= GRID_X_MIN) ? GRID_X_MAX : x - 5'd1;
      DIR_DOWN:  s.y = (y >= GRID_Y_MAX) ? 4'd0 : y + 4'd1;
      DIR_UP:    s.y = (y == 4'd0) ? GRID_Y_MAX : y - 4'd1;
      default:   s = s;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/snake_ring.sv
// Segment ring storage: one write port at the new head, one read port
// addressed as an offset back from the head pointer (0 = head).
module snake_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32,
  localparam int AW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  seg_t          wr_seg,
  input  logic [AW-1:0] head_ptr,
  input  logic [AW-1:0] rd_idx,
  output seg_t          rd_seg
);

  seg_t          mem [MAX_LEN];
  logic [AW-1:0] rd_addr;

  // Only the three starting segments need a defined value; every other
  // entry is written by a move before a walk can reach it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '{x: 5'd3, y: RESET_HEAD_Y, dir: DIR_RIGHT};
      mem[1] <= '{x: 5'd4, y: RESET_HEAD_Y, dir: DIR_RIGHT};
      mem[2] <= '{x: RESET_HEAD_X, y: RESET_HEAD_Y, dir: DIR_RIGHT};
    end else if (we) begin
      mem[wr_ptr] <= wr_seg;
    end
  end

  assign rd_addr = head_ptr - rd_idx;
  assign rd_seg  = mem[rd_addr];

endmodule

// File: rtl/snake_body.sv
// Snake body controller: ring of segments, walk streamer and single-tile mover.
// Optional SNAKE_SELF_COLLISION_EN adds a sticky head-vs-body collision flag.
//
// state   | meaning
// IDLE    | waiting; accepts line_start (priority) or move_req
// WALK    | streaming one segment per cycle, head to tail
// MOVE    | writing the stepped head into the ring, updating length
module snake_body
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  input  logic       grow,
  output logic       move_ready,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic [1:0] snake_dir,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic [4:0] head_x,
  output logic [3:0] head_y,
  output logic [6:0] length
`ifdef SNAKE_SELF_COLLISION_EN
  ,
  output logic       collision
`endif
);

  localparam int         AW      = $clog2(MAX_LEN);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_MOVE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] head_ptr;
  logic [6:0]    walk_idx;
  dir_t          mv_dir;
  logic          mv_grow;
  logic [AW-1:0] rd_idx;
  seg_t          rd_seg;
  seg_t          new_head;
  logic          ring_we;
  logic [AW-1:0] wr_ptr;

  assign move_ready = (state == ST_IDLE) && !line_start;
  assign new_head   = step_seg(head_x, head_y, mv_dir);
  assign ring_we    = (state == ST_MOVE);
  assign wr_ptr     = head_ptr + AW'(1);
  // In IDLE the read port already presents the head so the first beat
  // can be registered on the same edge that samples line_start.
  assign rd_idx     = (state == ST_WALK) ? walk_idx[AW-1:0] : '0;

  snake_ring #(.MAX_LEN(MAX_LEN)) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (ring_we),
    .wr_ptr   (wr_ptr),
    .wr_seg   (new_head),
    .head_ptr (head_ptr),
    .rd_idx   (rd_idx),
    .rd_seg   (rd_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      head_ptr    <= AW'(2);
      length      <= RESET_LEN;
      head_x      <= RESET_HEAD_X;
      head_y      <= RESET_HEAD_Y;
      walk_idx    <= '0;
      mv_dir      <= DIR_RIGHT;
      mv_grow     <= 1'b0;
      snake_x     <= '0;
      snake_y     <= '0;
      snake_dir   <= '0;
      snake_first <= 1'b0;
      snake_last  <= 1'b0;
      snake_valid <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
      collision   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            state       <= ST_WALK;
            snake_x     <= rd_seg.x;
            snake_y     <= rd_seg.y;
            snake_dir   <= rd_seg.dir;
            snake_first <= 1'b1;
            snake_last  <= (length == 7'd1);
            snake_valid <= 1'b1;
            walk_idx    <= 7'd1;
          end else if (move_req) begin
            state   <= ST_MOVE;
            mv_dir  <= dir_t'(move_dir);
            mv_grow <= grow;
          end
        end
        ST_WALK: begin
          if (walk_idx >= length) begin
            state       <= ST_IDLE;
            snake_x     <= '0;
            snake_y     <= '0;
            snake_dir   <= '0;
            snake_first <= 1'b0;
            snake_last  <= 1'b0;
            snake_valid <= 1'b0;
          end else begin
            snake_x     <= rd_seg.x;
            snake_y     <= rd_seg.y;
            snake_dir   <= rd_seg.dir;
            snake_first <= 1'b0;
            snake_last  <= (walk_idx == length - 7'd1);
            walk_idx    <= walk_idx + 7'd1;
`ifdef SNAKE_SELF_COLLISION_EN
            if (rd_seg.x == head_x && rd_seg.y == head_y) collision <= 1'b1;
`endif
          end
        end
        ST_MOVE: begin
          state    <= ST_IDLE;
          head_ptr <= wr_ptr;
          head_x   <= new_head.x;
          head_y   <= new_head.y;
          // At capacity a grow is a plain move: the ring overwrites the tail.
          if (mv_grow && length < LEN_MAX) length <= length + 7'd1;
`ifdef SNAKE_SELF_COLLISION_EN
          collision <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: expected walk beats are queued by the
// stimulus and popped by an independent negedge monitor.
module tb_snake_body;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic       move_req = 1'b0;
  logic [1:0] move_dir = 2'd0;
  logic       grow = 1'b0;
  logic       move_ready;
  logic [4:0] snake_x;
  logic [3:0] snake_y;
  logic [1:0] snake_dir;
  logic       snake_first, snake_last, snake_valid;
  logic [4:0] head_x;
  logic [3:0] head_y;
  logic [6:0] length;
`ifdef SNAKE_SELF_COLLISION_EN
  logic       collision;
`endif

  typedef struct {
    int x;
    int y;
    int d;
    int f;
    int l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    beat_cnt = 0;

  snake_body #(.MAX_LEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_start  (line_start),
    .move_req    (move_req),
    .move_dir    (move_dir),
    .grow        (grow),
    .move_ready  (move_ready),
    .snake_x     (snake_x),
    .snake_y     (snake_y),
    .snake_dir   (snake_dir),
    .snake_first (snake_first),
    .snake_last  (snake_last),
    .snake_valid (snake_valid),
    .head_x      (head_x),
    .head_y      (head_y),
    .length      (length)
`ifdef SNAKE_SELF_COLLISION_EN
    ,
    .collision   (collision)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every valid beat must match the head of the expected queue;
  // with valid low the stream fields must all be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (snake_valid) begin
        beat_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got x=%0d y=%0d dir=%0d", snake_x, snake_y, snake_dir);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (int'(snake_x) != e.x || int'(snake_y) != e.y || int'(snake_dir) != e.d ||
              int'(snake_first) != e.f || int'(snake_last) != e.l) begin
            bad++;
            $display("FAIL beat got x=%0d y=%0d dir=%0d f=%0d l=%0d want x=%0d y=%0d dir=%0d f=%0d l=%0d",
                     snake_x, snake_y, snake_dir, snake_first, snake_last,
                     e.x, e.y, e.d, e.f, e.l);
          end
        end
      end else begin
        total++;
        if ({snake_x, snake_y, snake_dir, snake_first, snake_last} != 13'd0) begin
          bad++;
          $display("FAIL idle_zero got x=%0d y=%0d dir=%0d f=%0d l=%0d want all 0",
                   snake_x, snake_y, snake_dir, snake_first, snake_last);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int d, input int f, input int l);
    beat_t b;
    b.x = x; b.y = y; b.d = d; b.f = f; b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    line_start = 1'b0; move_req = 1'b0; grow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_walk_end(input int n_exp, input string name);
    int guard;
    guard = 0;
    while (snake_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_beats"}, beat_cnt, n_exp);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_walk(input int n_exp, input string name);
    @(posedge clk); #1 line_start = 1'b1;
    beat_cnt = 0;
    @(posedge clk); #1 line_start = 1'b0;
    wait_walk_end(n_exp, name);
  endtask

  task automatic do_move(input int dir, input int g);
    @(posedge clk); #1 move_req = 1'b1; move_dir = 2'(dir); grow = g[0];
    #1 chk("move_ready_idle", int'(move_ready), 1);
    @(posedge clk); #1 move_req = 1'b0; grow = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_length", int'(length), 3);
    chk("rst_head_x", int'(head_x), 5);
    chk("rst_head_y", int'(head_y), 7);
    chk("rst_move_ready", int'(move_ready), 1);
    chk("rst_valid", int'(snake_valid), 0);
`ifdef SNAKE_SELF_COLLISION_EN
    chk("rst_collision", int'(collision), 0);
`endif

    // Walk the reset body
    push(5, 7, 0, 1, 0); push(4, 7, 0, 0, 0); push(3, 7, 0, 0, 1);
    do_walk(3, "walk_reset");
`ifdef SNAKE_SELF_COLLISION_EN
    chk("no_collision_reset_body", int'(collision), 0);
`endif

    // Plain move down
    do_move(1, 0);
    chk("down_head_x", int'(head_x), 5);
    chk("down_head_y", int'(head_y), 8);
    chk("down_length", int'(length), 3);
    push(5, 8, 1, 1, 0); push(5, 7, 0, 0, 0); push(4, 7, 0, 0, 1);
    do_walk(3, "walk_down");

    // Reset mid-walk aborts the stream
    push(5, 8, 1, 1, 0); push(5, 7, 0, 0, 0); push(4, 7, 0, 0, 1);
    @(posedge clk); #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", int'(snake_valid), 0);
    chk("abort_first", int'(snake_first), 0);
    chk("abort_head_y", int'(head_y), 7);
    rst_n = 1'b1;
    exp_q.delete();

    // X and Y wrap
    do_reset();
    for (int i = 0; i < 15; i++) do_move(0, 0);
    chk("pre_wrap_x", int'(head_x), 20);
    do_move(0, 0);
    chk("wrap_x_20_to_1", int'(head_x), 1);
    for (int i = 0; i < 7; i++) do_move(3, 0);
    chk("pre_wrap_y", int'(head_y), 0);
    do_move(3, 0);
    chk("wrap_y_0_to_14", int'(head_y), 14);
    chk("wrap_x_kept", int'(head_x), 1);
    push(1, 14, 3, 1, 0); push(1, 0, 3, 0, 0); push(1, 1, 3, 0, 1);
    do_walk(3, "walk_wrap");

    // line_start beats a simultaneous move_req; move_req during a walk is dropped
    push(1, 14, 3, 1, 0); push(1, 0, 3, 0, 0); push(1, 1, 3, 0, 1);
    @(posedge clk); #1 line_start = 1'b1; move_req = 1'b1; move_dir = 2'd1;
    beat_cnt = 0;
    #1 chk("ready_low_with_line_start", int'(move_ready), 0);
    @(posedge clk); #1 line_start = 1'b0; move_dir = 2'd0;
    chk("ready_low_in_walk", int'(move_ready), 0);
    @(posedge clk); #1 move_req = 1'b0;
    wait_walk_end(3, "walk_collide_req");
    repeat (3) @(posedge clk);
    #1;
    chk("dropped_head_x", int'(head_x), 1);
    chk("dropped_head_y", int'(head_y), 14);
    chk("dropped_length", int'(length), 3);

    // Growth saturates at capacity
    do_reset();
    for (int i = 0; i < 40; i++) do_move(0, 1);
    chk("sat_length", int'(length), 32);
    chk("sat_head_x", int'(head_x), 5);
    for (int i = 0; i < 32; i++)
      push(((44 - i) % 20) + 1, 7, 0, (i == 0) ? 1 : 0, (i == 31) ? 1 : 0);
    do_walk(32, "walk_sat");

`ifdef SNAKE_SELF_COLLISION_EN
    // Square loop at length 5 brings the head onto the tail
    do_reset();
    do_move(0, 1); do_move(0, 1);
    chk("coll_len5", int'(length), 5);
    do_move(0, 0); do_move(1, 0); do_move(2, 0); do_move(3, 0);
    chk("coll_cleared_by_move", int'(collision), 0);
    push(7, 7, 3, 1, 0); push(7, 8, 2, 0, 0); push(8, 8, 1, 0, 0);
    push(8, 7, 0, 0, 0); push(7, 7, 0, 0, 1);
    do_walk(5, "walk_coll");
    chk("collision_set", int'(collision), 1);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, meaning ring capacity in segments (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; it is synchronous and active-low.
REQ-004 SHALL have port line_start  input  1  one-cycle pulse requesting a walk of all segments.
REQ-005 SHALL have port move_req  input  1  request to advance the snake by one tile.
REQ-006 SHALL have port move_dir  input  2  direction of the move: 0 right, 1 down, 2 left, 3 up.
REQ-007 SHALL have port grow  input  1  sampled with move_req; when 1, the tail is kept.
REQ-008 SHALL have port move_ready  output  1  high when a move_req this cycle is accepted.
REQ-009 SHALL have ports snake_x, snake_y, snake_dir  output  5/4/2  streamed segment tile and direction.
REQ-010 SHALL have ports snake_first, snake_last, snake_valid  output  1 each  stream qualifiers.
REQ-011 SHALL have ports head_x, head_y  output  5/4  current head tile.
REQ-012 SHALL have port length  output  7  current segment count.

Function
REQ-013 SHALL store segments in a ring: head pointer, length counter; each entry holds x, y, and dir.
REQ-014 SHALL use the playfield x 1..20 and y 0..14; x 0 and 21 are border columns and are never produced.
REQ-015 SHALL implement FSM IDLE, WALK, MOVE; after reset it SHALL be in IDLE.
REQ-016 SHALL, in IDLE, enter WALK on line_start; line_start SHALL win over a simultaneous move_req.
REQ-017 SHALL assert move_ready only in IDLE with line_start low; move_req && move_ready SHALL enter MOVE.
REQ-018 SHALL, in WALK, emit one segment per cycle, head first, tail last; first segment on the cycle after line_start; snake_valid high for exactly length cycles.
REQ-019 SHALL set snake_first on the head beat and snake_last on the tail beat; both SHALL be set on one beat when length==1.
REQ-020 SHALL, with snake_valid low, drive snake_x/y/dir/first/last to 0.
REQ-021 SHALL ignore line_start and move_req while in WALK or MOVE (no queueing).
REQ-022 SHALL, in MOVE (one cycle), write new head = old head stepped by move_dir, with dir=move_dir, then return to IDLE.
REQ-023 SHALL wrap coordinates: x 20->1 and 1->20; y 14->0 and 0->14.
REQ-024 SHALL increment length on grow, saturating at MAX_LEN; at saturation, grow SHALL behave as a plain move (oldest segment overwritten).
REQ-025 SHALL leave length unchanged on a non-grow move (tail drops implicitly via the ring).
REQ-026 SHALL update head_x/head_y and length on the cycle after MOVE.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, abort any walk or move and return to IDLE; all stream outputs SHALL be 0 on the next cycle.
REQ-028 SHALL reset the body to length 3 with head (5,7), body (4,7) and (3,7), all dir right; head_x=5, head_y=7, move_ready=1.

Configuration
REQ-029 SHALL, with SNAKE_SELF_COLLISION_EN defined, add output collision (1 bit), set on any walk beat (snake_first low) whose x/y equals the head, held until the next MOVE or reset (reset value 0).
REQ-030 SHALL, without SNAKE_SELF_COLLISION_EN, have no collision port and no compare logic.

Structure
REQ-031 SHALL take dir_t (2-bit enum), seg_t (x, y, dir struct), and constants GRID_X_MIN=1, GRID_X_MAX=20, GRID_Y_MAX=14 from shared package snake_pkg.
REQ-032 SHALL place segment storage in sub-module snake_ring (one write port at head, one read port indexed from head).

Verification
REQ-033 SHALL cover: reset, then a line_start pulse -> three beats (5,7,first), (4,7), (3,7,last), all dir 0.
REQ-034 SHALL cover: move_req dir=1 with grow=0 -> walk gives (5,8) dir 1 first, (5,7), (4,7) last; length stays 3.
REQ-035 SHALL cover: head (20,7), move dir=0 -> head (1,7); head (x,0), move dir=3 -> head (x,14).
REQ-036 SHALL cover: line_start and move_req in the same cycle -> walk runs and move_ready=0; a move_req during the walk is dropped and the head is unchanged.
REQ-037 SHALL cover: 40 grow moves with MAX_LEN=32 -> length saturates at 32 and a walk has exactly 32 valid beats.
REQ-038 SHALL cover, under SNAKE_SELF_COLLISION_EN: moves right, down, left, up with grow at length 5 -> collision=1 after the next walk.
